pipe_stage_skid: RTL and testbench

//  Generic parametrised pipeline stage register for the processor datapath.

---
 rtl/pipe_stage_skid.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: data + control payload, valid/ready
// handshake, synchronous flush, optional 2-entry skid buffer.
// All state updates on the falling edge of clk; reset is asynchronous.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic accept;
    logic deliver;

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // state | meaning
            // EMPTY | no entries held, in_ready = 1
            // HALF  | head entry valid, in_ready = 1
            // FULL  | head and skid entries valid, in_ready = 0
            typedef enum logic [1:0] {
                EMPTY = 2'd0,
                HALF  = 2'd1,
                FULL  = 2'd2
            } state_t;

            state_t              state_q, state_d;
            logic                in_ready_q;
            logic                load_head, load_skid, promote;
            logic [DATA_W-1:0]   head_data_q, skid_data_q;
            logic [CTRL_W-1:0]   head_ctrl_q, skid_ctrl_q;

            // Next-state and storage-enable decode; flush squashes everything
            // except the deliver that downstream samples on this edge.
            always_comb begin
                state_d   = state_q;
                load_head = 1'b0;
                load_skid = 1'b0;
                promote   = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                state_d   = HALF;
                                load_head = 1'b1;
                            end
                        end
                        HALF: begin
                            if (accept && !deliver) begin
                                state_d   = FULL;
                                load_skid = 1'b1;
                            end else if (accept && deliver) begin
                                load_head = 1'b1;
                            end else if (deliver) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL: begin
                            if (deliver) begin
                                state_d = HALF;
                                promote = 1'b1;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            // State register with registered in_ready so it never depends on out_ready.
            always_ff @(negedge clk or posedge reset) begin
                if (reset) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != FULL);
                end
            end

            // Payload storage changes only on load or promotion, never while idle.
            always_ff @(negedge clk or posedge reset) begin
                if (reset) begin
                    head_data_q <= '0;
                    head_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    if (load_head) begin
                        head_data_q <= in_data;
                        head_ctrl_q <= in_ctrl;
                    end else if (promote) begin
                        head_data_q <= skid_data_q;
                        head_ctrl_q <= skid_ctrl_q;
                    end
                    if (load_skid) begin
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                    end
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != EMPTY);
            assign out_data  = head_data_q;
            assign out_ctrl  = out_valid ? head_ctrl_q : '0;
            assign occupancy = state_q;
        end else begin : g_single
            logic              valid_q;
            logic [DATA_W-1:0] data_q;
            logic [CTRL_W-1:0] ctrl_q;

            // Single entry: an accept alongside a deliver simply replaces it.
            always_ff @(negedge clk or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q <= 1'b1;
                end else if (deliver) begin
                    valid_q <= 1'b0;
                end
            end

            // Payload register loads only on an accept that is not squashed.
            always_ff @(negedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                    ctrl_q <= '0;
                end else if (accept && !flush) begin
                    data_q <= in_data;
                    ctrl_q <= in_ctrl;
                end
            end

            assign in_ready  = !valid_q | out_ready;
            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign out_ctrl  = valid_q ? ctrl_q : '0;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share the
// same stimulus; each has its own scoreboard queue checked by a monitor.
module tb_pipe_stage_skid;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [CW-1:0] oc1, oc0;
    logic [1:0]    occ1, occ0;

    int total = 0;
    int bad   = 0;
    logic [DW+CW-1:0] q1[$];
    logic [DW+CW-1:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_single (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
        .occupancy(occ0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for one instance: compares head on deliver, then updates its queue.
    task automatic sample(input int k, input logic ir, input logic ov,
                          input logic [DW-1:0] od, input logic [CW-1:0] oc,
                          input logic [1:0] occ);
        logic [DW+CW-1:0] e;
        int n;
        n = (k == 1) ? q1.size() : q0.size();
        chk((k == 1) ? "occ1" : "occ0", 64'(occ), 64'(n));
        chk((k == 1) ? "out_valid1" : "out_valid0", 64'(ov), 64'(n != 0));
        if (k == 1) chk("in_ready1", 64'(ir), 64'(n < 2));
        else        chk("in_ready0", 64'(ir), 64'((n == 0) || out_ready));
        if (!ov) chk((k == 1) ? "bubble_ctrl1" : "bubble_ctrl0", 64'(oc), 64'd0);
        if (ov && out_ready) begin
            if (n == 0) begin
                total++;
                bad++;
                $display("FAIL underflow%0d: got delivery %0h expected none", k, od);
            end else begin
                e = (k == 1) ? q1.pop_front() : q0.pop_front();
                chk((k == 1) ? "data1" : "data0", 64'(od), 64'(e[DW-1:0]));
                chk((k == 1) ? "ctrl1" : "ctrl0", 64'(oc), 64'(e[DW+CW-1:DW]));
            end
        end
        if (flush) begin
            if (k == 1) q1.delete(); else q0.delete();
        end else if (in_valid && ir) begin
            if (k == 1) q1.push_back({in_ctrl, in_data});
            else        q0.push_back({in_ctrl, in_data});
        end
    endtask

    // Monitor runs 3 time units after each rising edge, before the falling (active) edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (reset) begin
                q1.delete();
                q0.delete();
            end else begin
                sample(1, ir1, ov1, od1, oc1, occ1);
                sample(0, ir0, ov0, od0, oc0, occ0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = 16'hA000 ^ d[15:0];
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        chk("rst_out_valid", 64'(ov1), 64'd0);
        chk("rst_out_ctrl",  64'(oc1), 64'd0);
        chk("rst_out_data",  64'(od1), 64'd0);
        chk("rst_occ",       64'(occ1), 64'd0);
        chk("rst_in_ready",  64'(ir1), 64'd1);
        chk("rst_in_ready0", 64'(ir0), 64'd1);
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back stream, out_ready=1: one-cycle latency, occupancy 1.
        drive(1'b1, 32'd1, 1'b1, 1'b0); tick();
        chk("s2_valid", 64'(ov1), 64'd1);
        chk("s2_d1", 64'(od1), 64'd1);
        chk("s2_occ", 64'(occ1), 64'd1);
        chk("s2_d1_single", 64'(od0), 64'd1);
        drive(1'b1, 32'd2, 1'b1, 1'b0); tick();
        chk("s2_d2", 64'(od1), 64'd2);
        chk("s2_occ2", 64'(occ1), 64'd1);
        drive(1'b1, 32'd3, 1'b1, 1'b0); tick();
        chk("s2_d3", 64'(od1), 64'd3);
        chk("s2_c3", 64'(oc1), 64'hA003);
        drive(1'b0, 32'd0, 1'b1, 1'b0); tick();
        chk("s2_empty", 64'(ov1), 64'd0);
        chk("s2_bubble", 64'(oc1), 64'd0);

        // Stall with skid: A,B held, C refused until space frees.
        drive(1'b1, 32'h11, 1'b0, 1'b0); tick();
        chk("s3_occA", 64'(occ1), 64'd1);
        chk("s3_rdyA", 64'(ir1), 64'd1);
        drive(1'b1, 32'h22, 1'b0, 1'b0); tick();
        chk("s3_occB", 64'(occ1), 64'd2);
        chk("s3_rdyB", 64'(ir1), 64'd0);
        chk("s3_headA", 64'(od1), 64'h11);
        drive(1'b1, 32'h33, 1'b0, 1'b0); tick();
        chk("s3_occC", 64'(occ1), 64'd2);
        chk("s3_headA2", 64'(od1), 64'h11);
        drive(1'b1, 32'h33, 1'b1, 1'b0); tick();
        chk("s3_headB", 64'(od1), 64'h22);
        chk("s3_occ1", 64'(occ1), 64'd1);
        chk("s3_rdy1", 64'(ir1), 64'd1);
        tick();
        chk("s3_headC", 64'(od1), 64'h33);
        chk("s3_occC1", 64'(occ1), 64'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0); tick();
        chk("s3_drained", 64'(occ1), 64'd0);

        // Flush while FULL: A delivered on the flush edge, B and C dropped.
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h55, 1'b0, 1'b0); tick();
        chk("s4_full", 64'(occ1), 64'd2);
        chk("s4_headA", 64'(od1), 64'h44);
        drive(1'b1, 32'h66, 1'b1, 1'b1); tick();
        chk("s4_valid", 64'(ov1), 64'd0);
        chk("s4_ctrl", 64'(oc1), 64'd0);
        chk("s4_occ", 64'(occ1), 64'd0);
        chk("s4_rdy", 64'(ir1), 64'd1);
        chk("s4_valid0", 64'(ov0), 64'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0); tick();
        chk("s4_still_empty", 64'(ov1), 64'd0);

        // Single-entry stage: in_ready follows !out_valid|out_ready combinationally.
        drive(1'b1, 32'h71, 1'b1, 1'b0); tick();
        chk("s5_head71", 64'(od0), 64'h71);
        chk("s5_rdy_hi", 64'(ir0), 64'd1);
        drive(1'b1, 32'h72, 1'b0, 1'b0); #1;
        chk("s5_rdy_lo", 64'(ir0), 64'd0);
        tick();
        chk("s5_hold71", 64'(od0), 64'h71);
        drive(1'b1, 32'h72, 1'b1, 1'b0); #1;
        chk("s5_rdy_back", 64'(ir0), 64'd1);
        tick();
        chk("s5_head72", 64'(od0), 64'h72);
        drive(1'b0, 32'd0, 1'b1, 1'b0); tick();
        chk("s5_empty", 64'(ov0), 64'd0);

        // Asynchronous reset mid-cycle while FULL.
        drive(1'b1, 32'h81, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h82, 1'b0, 1'b0); tick();
        chk("s1_full", 64'(occ1), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("s1_valid", 64'(ov1), 64'd0);
        chk("s1_ctrl", 64'(oc1), 64'd0);
        chk("s1_occ", 64'(occ1), 64'd0);
        chk("s1_rdy", 64'(ir1), 64'd1);
        chk("s1_valid0", 64'(ov0), 64'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Random traffic against the scoreboards.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            tick();
        end
        tick();
        chk("drain_queues", 64'(q0.size() + q1.size()), 64'd0);
        chk("drain_occ", 64'(occ1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
